// File: rtl/fn4_pkg.sv
// Shared types and constants for the 4-input function sweep checker.
// Imported by the hold timer and the checker top.
package fn4_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  localparam logic [15:0] DEFAULT_EXPECTED = 16'hE8A6;

endpackage

// File: rtl/fn4_hold_timer.sv
// Loadable down-counter that times the settle window per vector.
// Expired is asserted while the count sits at zero.
module fn4_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/fn4_sweep_checker.sv
// Clocked sweep of all 16 {A,B,C,D} codes against a golden truth table.
// Samples y_in once per code and reports error count and first mismatch.
module fn4_sweep_checker
  import fn4_pkg::*;
#(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] EXPECTED    = DEFAULT_EXPECTED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               y_in,
  output logic [IDX_W-1:0]   abcd,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               first_err_vld,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic [NUM_VEC-1:0] observed
);

  localparam logic [7:0] LOAD_VAL = 8'(HOLD_CYCLES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             expired;
  logic             accept;
  logic             reload;
  logic             last;
  logic             miss;

  assign last   = (idx == 4'hF);
  assign miss   = (y_in != EXPECTED[idx]);
  assign accept = start && !abort &&
                  (state == IDLE || state == DONE);
  assign reload = accept ||
                  (!abort && state == SAMPLE && !last);

  fn4_hold_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (reload),
    .load_val (LOAD_VAL),
    .tick     (state == SETTLE),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      observed      <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SETTLE;
            idx           <= '0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            observed      <= '0;
          end
        end
        SETTLE: begin
          if (expired) state <= SAMPLE;
        end
        SAMPLE: begin
          observed[idx] <= y_in;
          if (miss) begin
            err_cnt <= err_cnt + 5'd1;
            if (!first_err_vld) begin
              first_err_idx <= idx;
              first_err_vld <= 1'b1;
            end
          end
          if (last) begin
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  always_comb begin
    abcd = '0;
    unique case (1'b1)
      busy:    abcd = idx;
      done:    abcd = 4'hF;
      default: abcd = '0;
    endcase
  end

endmodule

// File: tb/tb_fn4_sweep_checker.sv
// Scoreboard bench: stimulus queues expected sweep results,
// monitors compare them whenever done rises.
module tb_fn4_sweep_checker;
  import fn4_pkg::*;

  typedef struct {
    int          done_at;
    logic [4:0]  err;
    logic        fvld;
    logic [3:0]  fidx;
    logic [15:0] obs;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start0 = 1'b0, abort0 = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0;
  int   mode = 0;

  logic [3:0]  abcd0, abcd1, fidx0, fidx1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic        fvld0, fvld1, y0, y1;
  logic [4:0]  err0, err1;
  logic [15:0] obs0, obs1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  function automatic logic ymodel(logic [3:0] a, int m);
    logic [15:0] g;
    g = 16'hE8A6;
    case (m)
      1:       return g[a] ^ (a == 4'd5);
      2:       return 1'b0;
      default: return g[a];
    endcase
  endfunction

  assign y0 = ymodel(abcd0, mode);
  assign y1 = ymodel(abcd1, mode);

  fn4_sweep_checker #(.HOLD_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .y_in(y0), .abcd(abcd0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .first_err_vld(fvld0),
    .first_err_idx(fidx0), .observed(obs0)
  );

  fn4_sweep_checker #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .y_in(y1), .abcd(abcd1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .first_err_vld(fvld1),
    .first_err_idx(fidx1), .observed(obs1)
  );

  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp(string t, exp_t e, int c, logic [4:0] err,
                     logic fvld, logic [3:0] fidx,
                     logic [15:0] obs, logic pass);
    chk({t, "_done_cycle"}, c, e.done_at);
    chk({t, "_err_cnt"}, err, e.err);
    chk({t, "_first_vld"}, fvld, e.fvld);
    if (e.fvld) chk({t, "_first_idx"}, fidx, e.fidx);
    chk({t, "_observed"}, obs, e.obs);
    chk({t, "_pass"}, pass, e.pass);
  endtask

  logic d0q = 1'b0;
  logic d1q = 1'b0;
  exp_t m0, m1;

  always @(negedge clk) begin
    if (rst_n && done0 && !d0q) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_done", 1, 0);
      end else begin
        m0 = q0.pop_front();
        cmp("u0", m0, cyc, err0, fvld0, fidx0, obs0, pass0);
      end
    end
    d0q = done0;
  end

  always @(negedge clk) begin
    if (rst_n && done1 && !d1q) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_done", 1, 0);
      end else begin
        m1 = q1.pop_front();
        cmp("u1", m1, cyc, err1, fvld1, fidx1, obs1, pass1);
      end
    end
    d1q = done1;
  end

  function automatic exp_t mk(logic [4:0] err, logic fvld,
                              logic [3:0] fidx, logic [15:0] obs,
                              logic pass);
    exp_t e;
    e.done_at = 0;
    e.err = err; e.fvld = fvld; e.fidx = fidx;
    e.obs = obs; e.pass = pass;
    return e;
  endfunction

  task automatic go0(exp_t e);
    @(negedge clk);
    start0 = 1'b1;
    e.done_at = cyc + 1 + 16 * 5;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic go1(exp_t e);
    @(negedge clk);
    start1 = 1'b1;
    e.done_at = cyc + 1 + 16 * 2;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done0(string t);
    int n = 0;
    while (!done0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done0) chk({t, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done1(string t);
    int n = 0;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done1) chk({t, "_timeout"}, 0, 1);
  endtask

  task automatic chk_zero(string t);
    chk({t, "_abcd"}, abcd0, 0);
    chk({t, "_busy"}, busy0, 0);
    chk({t, "_done"}, done0, 0);
    chk({t, "_pass"}, pass0, 0);
    chk({t, "_err"}, err0, 0);
    chk({t, "_fvld"}, fvld0, 0);
    chk({t, "_fidx"}, fidx0, 0);
    chk({t, "_obs"}, obs0, 0);
  endtask

  initial begin
    exp_t good;
    int   n;
    good = mk(5'd0, 1'b0, 4'd0, 16'hE8A6, 1'b1);

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    mode = 0;
    go0(good);
    wait_done0("t1");
    @(negedge clk);
    chk("t1_done_abcd", abcd0, 4'hF);
    chk("t1_done_busy", busy0, 0);

    mode = 1;
    go0(mk(5'd1, 1'b1, 4'd5, 16'hE886, 1'b0));
    wait_done0("t2");

    mode = 2;
    go0(mk(5'd8, 1'b1, 4'd1, 16'h0000, 1'b0));
    wait_done0("t3");

    mode = 0;
    go0(good);
    n = 0;
    while (!(abcd0 == 4'd7 && busy0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_vec7", abcd0, 7);
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_abcd", abcd0, 0);
    chk("t4_busy", busy0, 0);
    chk("t4_done", done0, 0);
    chk("t4_pass", pass0, 0);
    chk("t4_partial_obs", obs0, 16'h0026);
    void'(q0.pop_back());
    @(negedge clk);
    abort0 = 1'b0;
    go0(good);
    wait_done0("t4b");

    go0(good);
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("t5_still_busy", busy0, 1);
    wait_done0("t5");
    @(negedge clk);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_both_busy", busy0, 0);
    chk("t5_both_done", done0, 0);
    chk("t5_both_abcd", abcd0, 0);
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_stays", busy0, 0);

    go0(good);
    repeat (19) @(posedge clk);
    #1;
    chk("t6_pre_abcd", abcd0, 3);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    void'(q0.pop_back());
    @(negedge clk);
    rst_n = 1'b1;

    go1(good);
    wait_done1("t6_u1");
    repeat (2) @(negedge clk);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
